// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC generator and fetch controller.
// Issues in-order fetch requests over a valid/ready handshake. It limits the
// number of accepted-but-unanswered fetches and applies redirects from
// execute. Stale in-flight responses are flagged for dropping via rsp_keep.
// Optional feature macro: FETCH_SEQ_ALIGN_TRAP_EN. When defined, a misaligned
// redirect target traps into a sticky FAULT state. When undefined, the low
// target bits are cleared and fault is tied low.
module fetch_sequencer #(
   parameter int unsigned       XLEN         = 32,
   parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
   parameter int unsigned       INST_BYTES   = 4,
   parameter int unsigned       MAX_INFLIGHT = 2,
   localparam int unsigned      CW           = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            halt,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            fetch_req_valid,
   input  logic            fetch_req_ready,
   output logic [XLEN-1:0] fetch_req_addr,
   input  logic            fetch_rsp_valid,
   output logic            rsp_keep,
   output logic [CW-1:0]   inflight,
   output logic            fault
);

   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_REDIRECT,
      ST_FAULT
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] tgt_q, tgt_d;
   logic            held_q, held_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   drop_q, drop_d;

   logic            req_valid;
   logic            issue_ok;
   logic            fire;
   logic            rsp_eff;
   logic [XLEN-1:0] tgt_in;

   // State and counter registers; reset clears everything, including any pending redirect
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_VECTOR;
         tgt_q      <= RESET_VECTOR;
         held_q     <= 1'b0;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         tgt_q      <= tgt_d;
         held_q     <= held_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   // Next-state logic: handshake, in-flight accounting, and redirect application
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      tgt_d      = tgt_q;
      held_d     = 1'b0;
      inflight_d = inflight_q;
      drop_d     = drop_q;

      // A held request stays asserted regardless of halt or the in-flight limit
      issue_ok  = (state_q == ST_RUN) && !halt && (inflight_q < CW'(MAX_INFLIGHT));
      req_valid = ((state_q == ST_RUN) || (state_q == ST_REDIRECT)) && (held_q || issue_ok);
      fire      = req_valid && fetch_req_ready;
      rsp_eff   = fetch_rsp_valid && (inflight_q != '0);
      tgt_in    = redirect_target & ~ALIGN_MASK;

      if (fire && !rsp_eff) begin
         inflight_d = inflight_q + CW'(1);
      end else if (!fire && rsp_eff) begin
         inflight_d = inflight_q - CW'(1);
      end

      if (rsp_eff && (drop_q != '0)) begin
         drop_d = drop_q - CW'(1);
      end

      if (fire) begin
         pc_d = pc_q + XLEN'(INST_BYTES);
      end

      held_d = req_valid && !fetch_req_ready;

      // Applying a redirect overrides the +INST_BYTES step. Everything still in
      // flight after this cycle's fire/response belongs to the old path.
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
            if (redirect_valid) begin
               pc_d   = tgt_in;
               drop_d = inflight_d;
            end
         end
         ST_RUN: begin
            if (redirect_valid) begin
               if (held_d) begin
                  tgt_d   = tgt_in;
                  state_d = ST_REDIRECT;
               end else begin
                  pc_d   = tgt_in;
                  drop_d = inflight_d;
               end
            end
         end
         ST_REDIRECT: begin
            if (redirect_valid) begin
               tgt_d = tgt_in;
            end
            if (fire) begin
               pc_d    = redirect_valid ? tgt_in : tgt_q;
               drop_d  = inflight_d;
               state_d = ST_RUN;
            end
         end
         default: begin
            held_d = 1'b0;
         end
      endcase

`ifdef FETCH_SEQ_ALIGN_TRAP_EN
      if (redirect_valid && (state_q != ST_FAULT) && ((redirect_target & ALIGN_MASK) != '0)) begin
         state_d = ST_FAULT;
         pc_d    = pc_q;
         tgt_d   = tgt_q;
         held_d  = 1'b0;
      end
`endif
   end

   assign fetch_req_valid = req_valid;
   assign fetch_req_addr  = pc_q;
   assign inflight        = inflight_q;
   assign rsp_keep        = fetch_rsp_valid && (drop_q == '0) && (state_q != ST_FAULT);

`ifdef FETCH_SEQ_ALIGN_TRAP_EN
   assign fault = (state_q == ST_FAULT);
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer. It runs directed scenarios with literal
// expectations, then randomized traffic. All traffic is checked every cycle
// against a path-epoch reference model: each issued fetch is tagged with the
// epoch current when it fired, and a response is kept only if its tag matches
// the current epoch.
module tb_fetch_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        halt;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        fetch_req_valid;
   logic        fetch_req_ready;
   logic [31:0] fetch_req_addr;
   logic        fetch_rsp_valid;
   logic        rsp_keep;
   logic [1:0]  inflight;
   logic        fault;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_pc;
   logic [31:0] m_ptgt;
   bit          m_boot;
   bit          m_pending;
   bit          m_holding;
   bit          m_faulted;
   int          m_epoch;
   int          m_q[$];

   fetch_sequencer #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0),
      .INST_BYTES   (4),
      .MAX_INFLIGHT (2)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .halt            (halt),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .fetch_req_valid (fetch_req_valid),
      .fetch_req_ready (fetch_req_ready),
      .fetch_req_addr  (fetch_req_addr),
      .fetch_rsp_valid (fetch_rsp_valid),
      .rsp_keep        (rsp_keep),
      .inflight        (inflight),
      .fault           (fault)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc      = 32'h0;
      m_ptgt    = 32'h0;
      m_boot    = 1'b1;
      m_pending = 1'b0;
      m_holding = 1'b0;
      m_faulted = 1'b0;
      m_epoch   = 0;
      m_q.delete();
   endtask

   function automatic bit m_valid();
      return !m_boot && !m_faulted &&
             (m_holding || (!halt && (m_q.size() < 2) && !m_pending));
   endfunction

   // Drive inputs (called at negedge), then compare all outputs with the model
   task automatic setup(input bit h, input bit rv, input logic [31:0] rt,
                        input bit rdy, input bit rsp);
      bit exp_keep;
      halt            = h;
      redirect_valid  = rv;
      redirect_target = rt;
      fetch_req_ready = rdy;
      fetch_rsp_valid = rsp;
      #1;
      exp_keep = rsp && !m_faulted && (m_q.size() > 0) && (m_q[0] == m_epoch);
      check("valid", 64'(fetch_req_valid), 64'(m_valid()));
      check("inflight", 64'(inflight), 64'(m_q.size()));
      check("fault", 64'(fault), 64'(m_faulted));
      check("rsp_keep", 64'(rsp_keep), 64'(exp_keep));
      if (!m_faulted) check("addr", 64'(fetch_req_addr), 64'(m_pc));
   endtask

   task automatic model_update(input bit v);
      bit          fire;
      logic [31:0] tgt;
      fire = v && fetch_req_ready;
      if (fetch_rsp_valid && (m_q.size() > 0)) void'(m_q.pop_front());
      if (m_faulted) return;
      if (fire) begin
         m_q.push_back(m_epoch);
         m_pc = m_pc + 32'd4;
      end
      tgt = redirect_target & ~32'h3;
`ifdef FETCH_SEQ_ALIGN_TRAP_EN
      if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
         m_faulted = 1'b1;
         m_holding = 1'b0;
         m_pending = 1'b0;
         return;
      end
`endif
      if (m_boot) begin
         m_boot = 1'b0;
         if (redirect_valid) begin
            m_pc = tgt;
            m_epoch++;
         end
      end else if (m_pending) begin
         if (redirect_valid) m_ptgt = tgt;
         if (fire) begin
            m_pc      = m_ptgt;
            m_epoch++;
            m_pending = 1'b0;
         end
      end else if (redirect_valid) begin
         if (v && !fetch_req_ready) begin
            m_pending = 1'b1;
            m_ptgt    = tgt;
         end else begin
            m_pc = tgt;
            m_epoch++;
         end
      end
      m_holding = v && !fetch_req_ready;
   endtask

   // Advance one clock: update the model at the edge, return at the next negedge
   task automatic clk_edge();
      bit v;
      v = m_valid();
      @(posedge clock);
      model_update(v);
      @(negedge clock);
   endtask

   // Asynchronous reset from the negedge point; returns at negedge in BOOT
   task automatic do_reset();
      halt            = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      fetch_req_ready = 1'b0;
      fetch_rsp_valid = 1'b0;
      reset           = 1'b1;
      #1;
      check("rst_valid", 64'(fetch_req_valid), 64'd0);
      check("rst_addr", 64'(fetch_req_addr), 64'h0);
      check("rst_inflight", 64'(inflight), 64'd0);
      check("rst_fault", 64'(fault), 64'd0);
      model_reset();
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] rt;
      reset           = 1'b1;
      halt            = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      fetch_req_ready = 1'b0;
      fetch_rsp_valid = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      do_reset();

      // Boot cycle: no request, then addresses 0 and 4 fire and the limit stops issue
      setup(0, 0, 32'h0, 1, 0);
      check("boot_valid", 64'(fetch_req_valid), 64'd0);
      clk_edge();
      setup(0, 0, 32'h0, 1, 0);
      check("first_addr", 64'(fetch_req_addr), 64'h0);
      clk_edge();
      setup(0, 0, 32'h0, 1, 0);
      check("second_addr", 64'(fetch_req_addr), 64'h4);
      clk_edge();
      setup(0, 0, 32'h0, 1, 0);
      check("limit_valid", 64'(fetch_req_valid), 64'd0);
      check("limit_inflight", 64'(inflight), 64'd2);
      clk_edge();

      // Hold under ready=0 and halt=1
      setup(0, 0, 32'h0, 0, 1);
      check("rsp_keep_a", 64'(rsp_keep), 64'd1);
      clk_edge();
      setup(0, 0, 32'h0, 0, 1);
      check("held_addr_a", 64'(fetch_req_addr), 64'h8);
      clk_edge();
      setup(1, 0, 32'h0, 0, 0);
      check("held_valid_halt", 64'(fetch_req_valid), 64'd1);
      check("held_addr_halt", 64'(fetch_req_addr), 64'h8);
      clk_edge();
      setup(1, 0, 32'h0, 1, 0);
      clk_edge();
      setup(1, 0, 32'h0, 1, 0);
      check("halt_no_issue", 64'(fetch_req_valid), 64'd0);
      clk_edge();
      setup(1, 0, 32'h0, 0, 1);
      clk_edge();

      // Redirect with two in flight: both responses dropped, the next one kept
      setup(0, 0, 32'h0, 1, 0);
      clk_edge();
      setup(0, 0, 32'h0, 1, 0);
      clk_edge();
      setup(0, 1, 32'h100, 1, 0);
      clk_edge();
      setup(0, 0, 32'h0, 0, 1);
      check("redir_drop1", 64'(rsp_keep), 64'd0);
      check("redir_addr", 64'(fetch_req_addr), 64'h100);
      clk_edge();
      setup(0, 0, 32'h0, 0, 1);
      check("redir_drop2", 64'(rsp_keep), 64'd0);
      clk_edge();
      setup(0, 0, 32'h0, 1, 0);
      clk_edge();
      setup(0, 0, 32'h0, 0, 1);
      check("redir_keep3", 64'(rsp_keep), 64'd1);
      clk_edge();

      // Redirect twice while a request is held: latest target wins, held fetch is stale
      setup(0, 1, 32'h40, 0, 0);
      check("pend_addr_a", 64'(fetch_req_addr), 64'h104);
      clk_edge();
      setup(0, 1, 32'h80, 0, 0);
      clk_edge();
      setup(0, 0, 32'h0, 1, 0);
      check("pend_fire_addr", 64'(fetch_req_addr), 64'h104);
      clk_edge();
      setup(0, 0, 32'h0, 0, 0);
      check("pend_new_addr", 64'(fetch_req_addr), 64'h80);
      check("pend_inflight", 64'(inflight), 64'd1);
      clk_edge();
      setup(0, 0, 32'h0, 1, 1);
      check("pend_stale_drop", 64'(rsp_keep), 64'd0);
      clk_edge();
      setup(0, 0, 32'h0, 0, 1);
      check("pend_keep", 64'(rsp_keep), 64'd1);
      clk_edge();

      // PC wrap at the top of the address space
      setup(0, 1, 32'hFFFF_FFFC, 1, 0);
      clk_edge();
      setup(0, 0, 32'h0, 1, 0);
      check("wrap_top", 64'(fetch_req_addr), 64'hFFFF_FFFC);
      clk_edge();
      setup(0, 0, 32'h0, 0, 0);
      check("wrap_zero", 64'(fetch_req_addr), 64'h0);
      check("wrap_fault", 64'(fault), 64'd0);
      clk_edge();
      setup(0, 0, 32'h0, 0, 1);
      clk_edge();
      setup(0, 0, 32'h0, 0, 1);
      clk_edge();

      // Randomized traffic with occasional mid-run resets
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         case ($urandom_range(0, 3))
            0:       rt = 32'hFFFF_FFF0 | ($urandom & 32'hC);
            default: rt = $urandom & ~32'h3;
         endcase
`ifndef FETCH_SEQ_ALIGN_TRAP_EN
         if ($urandom_range(0, 4) == 0) rt = $urandom;
`endif
         setup(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), rt,
               bit'($urandom_range(0, 1)),
               (m_q.size() > 0) && ($urandom_range(0, 2) == 0));
         clk_edge();
      end

      // Misaligned redirect target
      do_reset();
      setup(0, 0, 32'h0, 0, 0);
      clk_edge();
      setup(1, 1, 32'h102, 0, 0);
      clk_edge();
      setup(0, 0, 32'h0, 0, 0);
`ifdef FETCH_SEQ_ALIGN_TRAP_EN
      check("trap_fault", 64'(fault), 64'd1);
      check("trap_valid", 64'(fetch_req_valid), 64'd0);
`else
      check("clear_addr", 64'(fetch_req_addr), 64'h100);
      check("clear_valid", 64'(fetch_req_valid), 64'd1);
      check("clear_fault", 64'(fault), 64'd0);
`endif
      clk_edge();
      for (int i = 0; i < 4; i++) begin
         setup(0, 0, 32'h0, 1, (m_q.size() > 0));
         clk_edge();
      end
      do_reset();
      setup(0, 0, 32'h0, 0, 0);
      clk_edge();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
